// File: rtl/alu_req_arbiter.sv
// Round-robin front end sharing one cv32e40p_alu between two requesters.
// Latches the winner, drives the ALU through ISSUE/WAIT with a watchdog, and returns the result.
module alu_req_arbiter #(
    parameter int OP_WIDTH   = 7,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_LAT    = 40
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              req_valid_i,
    output logic [1:0]              req_ready_o,
    input  logic [2*OP_WIDTH-1:0]   req_op_i,
    input  logic [2*DATA_WIDTH-1:0] req_a_i,
    input  logic [2*DATA_WIDTH-1:0] req_b_i,
    input  logic [2*DATA_WIDTH-1:0] req_c_i,
    output logic [1:0]              rsp_valid_o,
    input  logic [1:0]              rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_result_o,
    output logic                    rsp_cmp_o,
    output logic                    rsp_err_o,
    output logic                    alu_enable_o,
    output logic [OP_WIDTH-1:0]     alu_operator_o,
    output logic [DATA_WIDTH-1:0]   alu_operand_a_o,
    output logic [DATA_WIDTH-1:0]   alu_operand_b_o,
    output logic [DATA_WIDTH-1:0]   alu_operand_c_o,
    output logic                    alu_ex_ready_o,
    input  logic [DATA_WIDTH-1:0]   alu_result_i,
    input  logic                    alu_cmp_i,
    input  logic                    alu_ready_i
);

    localparam int CNT_W = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LAT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  grant_idx_q, grant_idx_d;
    logic [OP_WIDTH-1:0]   op_q, op_d;
    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic                  cmp_q, cmp_d;
    logic                  err_q, err_d;
    logic                  grant_any;
    logic                  grant_sel;

    logic [OP_WIDTH-1:0]   op_arr [2];
    logic [DATA_WIDTH-1:0] a_arr  [2];
    logic [DATA_WIDTH-1:0] b_arr  [2];
    logic [DATA_WIDTH-1:0] c_arr  [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        assign op_arr[gi]      = req_op_i[gi*OP_WIDTH +: OP_WIDTH];
        assign a_arr[gi]       = req_a_i[gi*DATA_WIDTH +: DATA_WIDTH];
        assign b_arr[gi]       = req_b_i[gi*DATA_WIDTH +: DATA_WIDTH];
        assign c_arr[gi]       = req_c_i[gi*DATA_WIDTH +: DATA_WIDTH];
        assign rsp_valid_o[gi] = (state_q == RESP) && (grant_idx_q == 1'(gi));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_idx_q  <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            c_q          <= '0;
            cnt_q        <= '0;
            res_q        <= '0;
            cmp_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_idx_q  <= grant_idx_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            c_q          <= c_d;
            cnt_q        <= cnt_d;
            res_q        <= res_d;
            cmp_q        <= cmp_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        grant_idx_d    = grant_idx_q;
        op_d           = op_q;
        a_d            = a_q;
        b_d            = b_q;
        c_d            = c_q;
        cnt_d          = cnt_q;
        res_d          = res_q;
        cmp_d          = cmp_q;
        err_d          = err_q;
        req_ready_o    = 2'b00;
        alu_enable_o   = 1'b0;
        alu_ex_ready_o = 1'b0;
        grant_any      = 1'b0;
        grant_sel      = 1'b0;

        case (state_q)
            IDLE: begin
                // Contention goes to whoever did not win last time.
                if (req_valid_i == 2'b11) begin
                    grant_any = 1'b1;
                    grant_sel = ~last_grant_q;
                end else if (req_valid_i[0]) begin
                    grant_any = 1'b1;
                    grant_sel = 1'b0;
                end else if (req_valid_i[1]) begin
                    grant_any = 1'b1;
                    grant_sel = 1'b1;
                end
                if (grant_any && !rst) begin
                    req_ready_o  = grant_sel ? 2'b10 : 2'b01;
                    grant_idx_d  = grant_sel;
                    last_grant_d = grant_sel;
                    op_d         = op_arr[grant_sel];
                    a_d          = a_arr[grant_sel];
                    b_d          = b_arr[grant_sel];
                    c_d          = c_arr[grant_sel];
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                alu_enable_o = 1'b1;
                if (alu_ready_i) begin
                    alu_ex_ready_o = 1'b1;
                    res_d          = alu_result_i;
                    cmp_d          = alu_cmp_i;
                    err_d          = 1'b0;
                    state_d        = RESP;
                end else begin
                    cnt_d   = CNT_W'(1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                alu_enable_o = 1'b1;
                if (alu_ready_i) begin
                    alu_ex_ready_o = 1'b1;
                    res_d          = alu_result_i;
                    cmp_d          = alu_cmp_i;
                    err_d          = 1'b0;
                    cnt_d          = '0;
                    state_d        = RESP;
                end else if (cnt_q == CNT_MAX) begin
                    // Watchdog: the ALU is never told the op completed.
                    res_d   = '0;
                    cmp_d   = 1'b0;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready_i[grant_idx_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign alu_operator_o  = op_q;
    assign alu_operand_a_o = a_q;
    assign alu_operand_b_o = b_q;
    assign alu_operand_c_o = c_q;
    assign rsp_result_o    = res_q;
    assign rsp_cmp_o       = cmp_q;
    assign rsp_err_o       = err_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: stub ALU with per-op latency, queue-based scoreboard and
// a transaction-level model of grant order and response timing.
module tb_alu_req_arbiter;

    localparam int OPW  = 7;
    localparam int DW   = 32;
    localparam int MAXL = 40;
    localparam logic [6:0] OP_ADD  = 7'b0011000;
    localparam logic [6:0] OP_SUB  = 7'b0011001;
    localparam logic [6:0] OP_DIVU = 7'b0110000;
    localparam logic [6:0] OP_XOR  = 7'b0101111;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      req_valid_i = 2'b00;
    logic [1:0]      req_ready_o;
    logic [2*OPW-1:0] req_op_i = '0;
    logic [2*DW-1:0] req_a_i = '0;
    logic [2*DW-1:0] req_b_i = '0;
    logic [2*DW-1:0] req_c_i = '0;
    logic [1:0]      rsp_valid_o;
    logic [1:0]      rsp_ready_i = 2'b00;
    logic [DW-1:0]   rsp_result_o;
    logic            rsp_cmp_o;
    logic            rsp_err_o;
    logic            alu_enable_o;
    logic [OPW-1:0]  alu_operator_o;
    logic [DW-1:0]   alu_operand_a_o;
    logic [DW-1:0]   alu_operand_b_o;
    logic [DW-1:0]   alu_operand_c_o;
    logic            alu_ex_ready_o;
    logic [DW-1:0]   alu_result_i;
    logic            alu_cmp_i;
    logic            alu_ready_i;

    alu_req_arbiter #(.OP_WIDTH(OPW), .DATA_WIDTH(DW), .MAX_LAT(MAXL)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_op_i(req_op_i), .req_a_i(req_a_i), .req_b_i(req_b_i), .req_c_i(req_c_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_result_o(rsp_result_o), .rsp_cmp_o(rsp_cmp_o), .rsp_err_o(rsp_err_o),
        .alu_enable_o(alu_enable_o), .alu_operator_o(alu_operator_o),
        .alu_operand_a_o(alu_operand_a_o), .alu_operand_b_o(alu_operand_b_o),
        .alu_operand_c_o(alu_operand_c_o), .alu_ex_ready_o(alu_ex_ready_o),
        .alu_result_i(alu_result_i), .alu_cmp_i(alu_cmp_i), .alu_ready_i(alu_ready_i)
    );

    always #5 clk = ~clk;

    // Stub ALU: behaviour of a few operators, busy for cur_lat enabled cycles.
    function automatic logic [DW-1:0] alu_fn(input logic [6:0] op, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b, input logic [DW-1:0] c);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_DIVU: return (b == 0) ? '1 : a / b;
            default: return a ^ b ^ c;
        endcase
    endfunction

    int cyc = 0;
    int en_cnt = 0;
    int cur_lat = 0;
    int force_lat = 0;
    int mode = 2;
    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;
    logic [1:0] acc_seen = 2'b00;

    assign alu_result_i = alu_fn(alu_operator_o, alu_operand_a_o, alu_operand_b_o, alu_operand_c_o);
    assign alu_cmp_i    = alu_operand_a_o < alu_operand_b_o;
    assign alu_ready_i  = alu_enable_o && (en_cnt >= cur_lat);

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        en_cnt <= alu_enable_o ? en_cnt + 1 : 0;
    end

    typedef struct {
        int            idx;
        logic [6:0]    op;
        logic [DW-1:0] a, b, c, res;
        logic          cmp, err;
        int            acc_cyc, vcyc;
    } exp_t;

    exp_t sbq[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard: samples on the falling edge.
    initial begin
        exp_t f, e;
        logic [1:0] exp_rdy, exp_val;
        logic exp_en;
        int model_last, exr, lat, eff;
        bit busy;
        model_last = 1;
        exr = 0;
        forever begin
            @(negedge clk);
            acc_seen = 2'b00;
            if (!mon_en) continue;
            busy = (sbq.size() != 0);

            exp_rdy = 2'b00;
            if (!rst && !busy) begin
                if (req_valid_i == 2'b11) exp_rdy = (model_last == 1) ? 2'b01 : 2'b10;
                else exp_rdy = req_valid_i;
            end
            chk("req_ready", req_ready_o, exp_rdy);

            exp_val = 2'b00;
            exp_en  = 1'b0;
            if (busy) begin
                f = sbq[0];
                if (cyc >= f.vcyc) exp_val = (f.idx == 1) ? 2'b10 : 2'b01;
                exp_en = (cyc > f.acc_cyc) && (cyc < f.vcyc);
            end
            chk("rsp_valid", rsp_valid_o, exp_val);
            chk("alu_enable", alu_enable_o, exp_en);

            if (busy && exp_en)
                chk("alu_operands", {alu_operator_o, alu_operand_a_o, alu_operand_b_o, alu_operand_c_o},
                    {f.op, f.a, f.b, f.c});
            if (busy && alu_ex_ready_o) exr++;
            if (busy && exp_val != 2'b00)
                chk("rsp_payload", {rsp_result_o, rsp_cmp_o, rsp_err_o}, {f.res, f.cmp, f.err});

            if (busy && !rst && exp_val != 2'b00 && rsp_ready_i[f.idx]) begin
                chk("ex_ready_pulses", exr, f.err ? 0 : 1);
                $display("[TB] rsp req%0d op=%b a=%0d b=%0d result=%0d cmp=%0d err=%0d cycles=%0d",
                         f.idx, f.op, f.a, f.b, rsp_result_o, rsp_cmp_o, rsp_err_o, f.vcyc - f.acc_cyc);
                void'(sbq.pop_front());
                exr = 0;
            end

            if (exp_rdy == 2'b01 || exp_rdy == 2'b10) begin
                e.idx = (exp_rdy == 2'b10) ? 1 : 0;
                e.op  = req_op_i[e.idx*OPW +: OPW];
                e.a   = req_a_i[e.idx*DW +: DW];
                e.b   = req_b_i[e.idx*DW +: DW];
                e.c   = req_c_i[e.idx*DW +: DW];
                if (force_lat >= 0) lat = force_lat;
                else if ($urandom_range(0, 19) < 14) lat = $urandom_range(0, 3);
                else if ($urandom_range(0, 3) != 0) lat = $urandom_range(4, MAXL);
                else lat = MAXL + 1 + $urandom_range(0, 5);
                cur_lat   = lat;
                e.err     = (lat > MAXL);
                eff       = e.err ? MAXL : lat;
                e.res     = e.err ? '0 : alu_fn(e.op, e.a, e.b, e.c);
                e.cmp     = e.err ? 1'b0 : (e.a < e.b);
                e.acc_cyc = cyc;
                e.vcyc    = cyc + 2 + eff;
                sbq.push_back(e);
                model_last = e.idx;
                acc_seen   = exp_rdy;
            end

            if (rst) begin
                sbq.delete();
                model_last = 1;
                exr = 0;
            end
        end
    end

    task automatic set_req(input int i, input logic [6:0] op, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input logic [DW-1:0] c);
        req_op_i[i*OPW +: OPW] = op;
        req_a_i[i*DW +: DW]    = a;
        req_b_i[i*DW +: DW]    = b;
        req_c_i[i*DW +: DW]    = c;
        req_valid_i[i]         = 1'b1;
    endtask

    task automatic new_req(input int i, input bit add_only);
        logic [6:0] op;
        case ($urandom_range(0, 3))
            0: op = OP_ADD;
            1: op = OP_SUB;
            2: op = OP_DIVU;
            default: op = OP_XOR;
        endcase
        if (add_only) op = OP_ADD;
        set_req(i, op, $urandom, (op == OP_DIVU) ? 32'($urandom_range(0, 255)) : $urandom, $urandom);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (acc_seen[i]) begin
                if (mode == 0) new_req(i, 1'b1);
                else req_valid_i[i] = 1'b0;
            end
        end
        if (mode == 1) begin
            for (int i = 0; i < 2; i++)
                if (!req_valid_i[i] && $urandom_range(0, 2) == 0) new_req(i, 1'b0);
            rsp_ready_i = ($urandom_range(0, 3) != 0) ? 2'b11 : 2'b00;
        end
    endtask

    task automatic drain(input int bp);
        int left;
        int n;
        left = bp;
        n = 0;
        mode = 2;
        rsp_ready_i = (bp > 0) ? 2'b00 : 2'b11;
        while ((sbq.size() != 0 || req_valid_i != 2'b00) && n < 300) begin
            step();
            n++;
            if (rsp_valid_o != 2'b00) begin
                if (left > 0) begin
                    rsp_ready_i = 2'b00;
                    left--;
                end else begin
                    rsp_ready_i = 2'b11;
                end
            end
        end
        chk("drain_bound", (n < 300), 1);
    endtask

    initial begin
        int n;
        // Reset with both requesters asking.
        force_lat = 0;
        new_req(0, 1'b1);
        new_req(1, 1'b1);
        repeat (2) begin
            @(negedge clk);
            chk("reset_req_ready", req_ready_o, 2'b00);
            chk("reset_rsp_valid", rsp_valid_o, 2'b00);
            chk("reset_alu_enable", alu_enable_o, 1'b0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        rsp_ready_i = 2'b11;

        // Fairness: both valid back to back.
        mode = 0;
        repeat (24) step();
        drain(0);

        // Single ADD 5+7.
        force_lat = 0;
        set_req(0, OP_ADD, 5, 7, 0);
        drain(0);

        // DIVU 100/7 with 34 busy cycles.
        force_lat = 34;
        set_req(1, OP_DIVU, 100, 7, 0);
        drain(0);

        // Backpressure while requester 0 waits.
        force_lat = 0;
        mode = 2;
        set_req(1, OP_SUB, 50, 8, 0);
        n = 0;
        while (!acc_seen[1] && n < 20) begin
            step();
            n++;
        end
        chk("bp_accept", acc_seen[1], 1'b1);
        set_req(0, OP_ADD, 1000, 24, 0);
        drain(5);

        // Watchdog timeout.
        force_lat = 60;
        set_req(0, OP_ADD, 3, 4, 0);
        drain(0);

        // Reset in WAIT discards the op.
        force_lat = 100;
        mode = 2;
        rsp_ready_i = 2'b11;
        set_req(1, OP_DIVU, 50, 3, 0);
        n = 0;
        while (!acc_seen[1] && n < 20) begin
            step();
            n++;
        end
        chk("rst_wait_accept", acc_seen[1], 1'b1);
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (50) step();

        // Randomized traffic.
        force_lat = -1;
        mode = 1;
        repeat (2500) step();
        drain(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
